// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/halt/step/reset sequencer producing clock-enable and reset for the core
module cpu_run_ctrl #(
    parameter int DIV_W    = 17,
    parameter int DEB_W    = 16,
    parameter int RST_HOLD = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sw_run,
    input  logic             sw_step,
    input  logic             sw_cpu_rst,
    input  logic [1:0]       rate_sel,
    output logic             cpu_ce,
    output logic             cpu_reset,
    output logic             halted,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] ce_count
);

    localparam logic [1:0] ST_RST  = 2'd0;
    localparam logic [1:0] ST_HALT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_STEP = 2'd3;

    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [DEB_W-1:0]  DEB_MAX   = '1;
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);

    // Input channel order: 0 = run, 1 = step, 2 = cpu reset request
    logic [2:0]             raw_in;
    logic [2:0]             sync1_q, sync1_d;
    logic [2:0]             sync2_q, sync2_d;
    logic [2:0]             db_q, db_d;
    logic [2:0][DEB_W-1:0]  deb_cnt_q, deb_cnt_d;

    logic [DIV_W-1:0]       div_q, div_d;
    logic [1:0]             rate_q, rate_d;
    logic [DIV_W-1:0]       tick_mask;
    logic                   tick;
    int                     tick_k;

    logic [1:0]             state_q, state_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   cpu_ce_q, cpu_ce_d;
    logic                   cpu_reset_q, cpu_reset_d;
    logic                   halted_q, halted_d;
    logic [CNT_W-1:0]       ce_count_q, ce_count_d;

    // The FSM acts on the debounced values in the same cycle they are accepted,
    // so a simultaneous run/step acceptance is resolved consistently by priority.
    logic                   run_db;
    logic                   rst_db;
    logic                   step_evt;

    assign raw_in   = {sw_cpu_rst, sw_step, sw_run};
    assign run_db   = db_d[0];
    assign rst_db   = db_d[2];
    assign step_evt = db_d[1] & ~db_q[1];

    // Synchronize each switch, then accept a new level only after it has held steady
    always_comb begin
        sync1_d   = raw_in;
        sync2_d   = sync1_q;
        db_d      = db_q;
        deb_cnt_d = deb_cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_MAX) begin
                db_d[i]      = sync2_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
            end
        end
    end

    // Free-running divider; the rate in use only changes on a tick so pulses never double up
    always_comb begin
        div_d = div_q + DIV_ONE;
        case (rate_q)
            2'd0:    tick_k = 0;
            2'd1:    tick_k = DIV_W - 8;
            2'd2:    tick_k = DIV_W - 4;
            default: tick_k = DIV_W;
        endcase
        tick_mask = (DIV_ONE << tick_k) - DIV_ONE;
        tick      = &(div_q | ~tick_mask);
        rate_d    = tick ? rate_sel : rate_q;
    end

    // Next-state logic: reset request beats run, run beats a step press
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (rst_db) begin
            state_d = ST_RST;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_RST: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = run_db ? ST_RUN : ST_HALT;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                ST_HALT: begin
                    if (run_db) begin
                        state_d = ST_RUN;
                    end else if (step_evt) begin
                        state_d = ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (!run_db) begin
                        state_d = ST_HALT;
                    end
                end
                ST_STEP: begin
                    state_d = ST_HALT;
                end
            endcase
        end
    end

    // Output decode from the current state; a reset request during STEP suppresses its pulse
    always_comb begin
        cpu_reset_d = (state_q == ST_RST);
        halted_d    = (state_q == ST_HALT);
        case (state_q)
            ST_RST:  cpu_ce_d = 1'b1;
            ST_RUN:  cpu_ce_d = tick;
            ST_STEP: cpu_ce_d = ~rst_db;
            default: cpu_ce_d = 1'b0;
        endcase
        if (state_q == ST_RST) begin
            ce_count_d = '0;
        end else if (cpu_ce_d) begin
            ce_count_d = ce_count_q + CNT_W'(1);
        end else begin
            ce_count_d = ce_count_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            deb_cnt_q   <= '0;
            div_q       <= '0;
            rate_q      <= '0;
            state_q     <= ST_RST;
            hold_q      <= '0;
            cpu_ce_q    <= 1'b0;
            cpu_reset_q <= 1'b1;
            halted_q    <= 1'b0;
            ce_count_q  <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_q        <= db_d;
            deb_cnt_q   <= deb_cnt_d;
            div_q       <= div_d;
            rate_q      <= rate_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            cpu_ce_q    <= cpu_ce_d;
            cpu_reset_q <= cpu_reset_d;
            halted_q    <= halted_d;
            ce_count_q  <= ce_count_d;
        end
    end

    assign cpu_ce    = cpu_ce_q;
    assign cpu_reset = cpu_reset_q;
    assign halted    = halted_q;
    assign state_o   = state_q;
    assign ce_count  = ce_count_q;

endmodule
